dm_responder: RTL and testbench

- Multi-cycle data-memory responder: the memory-side end of the CPU's load/store interface.
- Accepts word-addressed read/write requests over a req/ack handshake.
- Inserts a programmable number of wait states, merges byte-lane writes and reports out-of-range addresses.
- Replaces the combinational data memory once the CPU moves to a stallable, multi-cycle memory path.

---
 rtl/dm_pkg.sv | 17 +
 rtl/dm_if.sv | 17 +
 rtl/dm_array.sv | 27 ++
 rtl/dm_responder.sv | 104 ++++++++++
 tb/tb_dm_responder.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dm_pkg;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_t;

  localparam int unsigned BE_W = 4;

  // An address is in range when every bit above the word index is zero.
  function automatic logic dm_addr_ok(input logic [31:0] a, input int unsigned aw);
    return (a >> aw) == 32'd0;
  endfunction

endpackage

// File: rtl/dm_if.sv
// Load/store request/response bundle between the CPU and the data-memory responder.
interface dm_if;
  import dm_pkg::*;

  logic            req;
  logic            we;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [BE_W-1:0] be;
  logic [31:0]     rdata;
  logic            ack;
  logic            err;
  logic            busy;

  modport master (output req, we, addr, wdata, be, input rdata, ack, err, busy);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack, err, busy);
endinterface

// File: rtl/dm_array.sv
// Single-port word array: combinational read, synchronous byte-enabled write.
module dm_array
  import dm_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   idx,
  input  logic [31:0]     wdata,
  input  logic [BE_W-1:0] be,
  output logic [31:0]     rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dm_responder.sv
// Memory-side end of the CPU load/store path: captures a request, waits LATENCY cycles, then acks.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned AW      = 8,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DW      = 32
) (
  input logic clk,
  input logic rst,
  dm_if.slave bus
);

  dm_state_t       state;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx_q;
  logic            we_q;
  logic            oor_q;
  logic [DW-1:0]   wdata_q;
  logic [BE_W-1:0] be_q;
  logic            ack_r;
  logic            err_r;
  logic            busy_r;
  logic [DW-1:0]   rdata_r;

  logic [AW-1:0]   arr_idx;
  logic [DW-1:0]   arr_rdata;
  logic            arr_we;
  logic            cap_oor;

  // The single array port looks at the live address while idle so a zero-latency
  // read can register its data on the capture edge; otherwise it uses the captured index.
  assign arr_idx = (state == DM_IDLE) ? bus.addr[AW-1:0] : idx_q;
  assign cap_oor = !dm_addr_ok(bus.addr, AW);
  assign arr_we  = (state == DM_RESP) && we_q && !oor_q && !rst;

  dm_array #(.AW(AW)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (wdata_q),
    .be    (be_q),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DM_IDLE;
      cnt     <= '0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      rdata_r <= '0;
    end else begin
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= '0;
      case (state)
        DM_IDLE: begin
          if (bus.req) begin
            idx_q   <= bus.addr[AW-1:0];
            we_q    <= bus.we;
            oor_q   <= cap_oor;
            wdata_q <= bus.wdata;
            be_q    <= bus.be;
            cnt     <= 4'(LATENCY);
            busy_r  <= 1'b1;
            if (LATENCY == 0) begin
              state   <= DM_RESP;
              ack_r   <= 1'b1;
              err_r   <= cap_oor;
              rdata_r <= (!bus.we && !cap_oor) ? arr_rdata : '0;
            end else begin
              state <= DM_WAIT;
            end
          end
        end
        DM_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state   <= DM_RESP;
            ack_r   <= 1'b1;
            err_r   <= oor_q;
            rdata_r <= (!we_q && !oor_q) ? arr_rdata : '0;
          end
        end
        DM_RESP: begin
          state  <= DM_IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= DM_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack   = ack_r;
  assign bus.err   = err_r;
  assign bus.busy  = busy_r;
  assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder at LATENCY = 0 and LATENCY = 2.
module tb_dm_responder;
  import dm_pkg::*;

  logic clk = 1'b0;
  logic rst0, rst2;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dm_if b0 ();
  dm_if b2 ();

  dm_responder #(.AW(8), .LATENCY(0), .DW(32)) u_dut0 (.clk(clk), .rst(rst0), .bus(b0.slave));
  dm_responder #(.AW(8), .LATENCY(2), .DW(32)) u_dut2 (.clk(clk), .rst(rst2), .bus(b2.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel0, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] e);
    if (sel0) begin
      b0.req = r; b0.we = w; b0.addr = a; b0.wdata = d; b0.be = e;
    end else begin
      b2.req = r; b2.we = w; b2.addr = a; b2.wdata = d; b2.be = e;
    end
  endtask

  task automatic sample(input bit sel0, output logic ack, output logic err,
                        output logic busy, output logic [31:0] rd);
    if (sel0) begin
      ack = b0.ack; err = b0.err; busy = b0.busy; rd = b0.rdata;
    end else begin
      ack = b2.ack; err = b2.err; busy = b2.busy; rd = b2.rdata;
    end
  endtask

  // Issues one transaction from cycle 0 and checks latency, busy, data and err.
  task automatic txn(input string tag, input bit sel0, input logic w,
                     input logic [31:0] a, input logic [31:0] d, input logic [3:0] e,
                     input int lat, input logic [31:0] exp_rd, input logic exp_err);
    logic ack, err, busy;
    logic [31:0] rd;
    int n = 0;
    bit got = 0;
    drive(sel0, 1'b1, w, a, d, e);
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      sample(sel0, ack, err, busy, rd);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (ack) got = 1;
    end
    chk({tag, "_lat"}, n, lat + 1);
    if (got) begin
      chk({tag, "_rdata"}, rd, exp_rd);
      chk({tag, "_err"}, 32'(err), 32'(exp_err));
    end
    drive(sel0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    sample(sel0, ack, err, busy, rd);
    chk({tag, "_idle"}, {ack, err, busy, rd[28:0]}, 32'h0);
  endtask

  // Holds a read request high and checks ack spacing.
  task automatic held(input string tag, input bit sel0, input logic [31:0] a,
                      input int lat, input int exp_acks);
    logic ack, err, busy;
    logic [31:0] rd;
    int prev = -1;
    int nacks = 0;
    drive(sel0, 1'b1, 1'b0, a, 32'h0, 4'h0);
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      sample(sel0, ack, err, busy, rd);
      if (ack) begin
        if (prev < 0) chk({tag, "_first"}, k, lat + 1);
        else          chk({tag, "_gap"}, k - prev, lat + 2);
        prev = k;
        nacks++;
      end
    end
    chk({tag, "_nacks"}, nacks, exp_acks);
    drive(sel0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (lat + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic ack, err, busy;
    logic [31:0] rd;

    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst0 = 1'b1;
    rst2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_dut0", {b0.ack, b0.err, b0.busy, b0.rdata[28:0]}, 32'h0);
      chk("rst_dut2", {b2.ack, b2.err, b2.busy, b2.rdata[28:0]}, 32'h0);
    end
    rst0 = 1'b0;
    rst2 = 1'b0;
    @(posedge clk); #1;
    chk("idle_dut2", {b2.ack, b2.err, b2.busy, b2.rdata[28:0]}, 32'h0);

    // Full write, read back, lane merge, empty-lane write
    txn("wr_full",  1'b0, 1'b1, 32'h05, 32'hDEADBEEF, 4'hF, 2, 32'h0, 1'b0);
    txn("rd_full",  1'b0, 1'b0, 32'h05, 32'h0,        4'hF, 2, 32'hDEADBEEF, 1'b0);
    txn("wr_lane",  1'b0, 1'b1, 32'h05, 32'h00001122, 4'h3, 2, 32'h0, 1'b0);
    txn("rd_lane",  1'b0, 1'b0, 32'h05, 32'h0,        4'h0, 2, 32'hDEAD1122, 1'b0);
    txn("wr_be0",   1'b0, 1'b1, 32'h05, 32'hFFFFFFFF, 4'h0, 2, 32'h0, 1'b0);
    txn("rd_be0",   1'b0, 1'b0, 32'h05, 32'h0,        4'h0, 2, 32'hDEAD1122, 1'b0);

    // Out of range: 0x100 aliases index 0, which must stay untouched
    txn("wr_a0",    1'b0, 1'b1, 32'h00,  32'hA5A5A5A5, 4'hF, 2, 32'h0, 1'b0);
    txn("wr_oor",   1'b0, 1'b1, 32'h100, 32'h12345678, 4'hF, 2, 32'h0, 1'b1);
    txn("rd_oor",   1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 2, 32'h0, 1'b1);
    txn("rd_a0",    1'b0, 1'b0, 32'h00,  32'h0,        4'h0, 2, 32'hA5A5A5A5, 1'b0);

    // Zero-latency instance
    txn("l0_wr",    1'b1, 1'b1, 32'h10, 32'h01020304, 4'hF, 0, 32'h0, 1'b0);
    txn("l0_rd",    1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 0, 32'h01020304, 1'b0);
    txn("l0_oor",   1'b1, 1'b0, 32'h80000010, 32'h0,  4'h0, 0, 32'h0, 1'b1);

    // Held request
    held("held2", 1'b0, 32'h05, 2, 3);
    held("held0", 1'b1, 32'h10, 0, 7);

    // Reset during WAIT of a write
    txn("wr_a7",    1'b0, 1'b1, 32'h07, 32'h11112222, 4'hF, 2, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'h07, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    chk("rw_busy", 32'(b2.busy), 32'd1);
    rst2 = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      sample(1'b0, ack, err, busy, rd);
      chk("rw_abort", {ack, busy}, 32'h0);
    end
    rst2 = 1'b0;
    txn("rd_a7_w",  1'b0, 1'b0, 32'h07, 32'h0, 4'h0, 2, 32'h11112222, 1'b0);

    // Reset during RESP of a write
    drive(1'b0, 1'b1, 1'b1, 32'h07, 32'h0BADF00D, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    chk("rr_ack", 32'(b2.ack), 32'd1);
    rst2 = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    sample(1'b0, ack, err, busy, rd);
    chk("rr_abort", {ack, busy}, 32'h0);
    rst2 = 1'b0;
    txn("rd_a7_r",  1'b0, 1'b0, 32'h07, 32'h0, 4'h0, 2, 32'h11112222, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
